// File: rtl/sdp_bs_operand_join_if.sv
// Operand bus bundle for sdp_bs_operand_join.
//   brdma_alu_* : ALU operand stream from the BS read-DMA ({last,data} payload)
//   brdma_mul_* : MUL operand stream from the BS read-DMA ({last,data} payload)
//   bs_op_*     : joined operand beat towards the BS ALU/MUL datapath
// Modports: slave = join block view, master = surrounding logic view.
interface sdp_bs_operand_join_if #(
    parameter int unsigned DW = 512
);
    logic          brdma_alu_valid;
    logic          brdma_alu_ready;
    logic [DW:0]   brdma_alu_pd;
    logic          brdma_mul_valid;
    logic          brdma_mul_ready;
    logic [DW:0]   brdma_mul_pd;
    logic          bs_op_valid;
    logic          bs_op_ready;
    logic [DW-1:0] bs_op_alu_data;
    logic [DW-1:0] bs_op_mul_data;
    logic          bs_op_last;

    modport slave (
        input  brdma_alu_valid, brdma_alu_pd, brdma_mul_valid, brdma_mul_pd, bs_op_ready,
        output brdma_alu_ready, brdma_mul_ready, bs_op_valid, bs_op_alu_data, bs_op_mul_data,
               bs_op_last
    );

    modport master (
        output brdma_alu_valid, brdma_alu_pd, brdma_mul_valid, brdma_mul_pd, bs_op_ready,
        input  brdma_alu_ready, brdma_mul_ready, bs_op_valid, bs_op_alu_data, bs_op_mul_data,
               bs_op_last
    );
endinterface

// File: rtl/sdp_bs_operand_join.sv
// SDP BS operand join: buffers the ALU and MUL operand streams in small FIFOs,
// aligns them according to the latched data_use mode and hands one joined beat
// per handshake to the BS datapath. Pulses op_done after the layer's last beat.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, asynchronous active-high reset
//   reg2dp_op_en                    : layer enable (level)
//   reg2dp_brdma_data_use           : 0=MUL only, 1=ALU only, 2/3=both
//   io (slave)                      : brdma_alu_*, brdma_mul_* in; bs_op_* out
//   op_done                         : one-cycle pulse when the layer completes
//   op_err                          : sticky last-flag mismatch in both mode
//   dp2reg_bs_opjoin_stall          : stall cycle counter (SDP_BS_OPJOIN_PERF_EN only)
// Optional feature macro: SDP_BS_OPJOIN_PERF_EN
module sdp_bs_operand_join #(
    parameter int unsigned DW    = 512,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 reg2dp_op_en,
    input  logic [1:0]           reg2dp_brdma_data_use,
    sdp_bs_operand_join_if.slave io,
    output logic                 op_done,
    output logic                 op_err
`ifdef SDP_BS_OPJOIN_PERF_EN
    ,
    output logic [31:0]          dp2reg_bs_opjoin_stall
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          start;
    logic          run;
    logic [1:0]    use_r;
    logic          use_alu;
    logic          use_mul;
    logic          fire;
    logic          last_c;
    logic          mismatch;

    logic [PW-1:0] alu_wp, alu_rp, mul_wp, mul_rp;
    logic [DW:0]   alu_mem [DEPTH];
    logic [DW:0]   mul_mem [DEPTH];
    logic [DW:0]   alu_head, mul_head;
    logic          alu_full, alu_empty, mul_full, mul_empty;
    logic          alu_push, alu_pop, mul_push, mul_pop;

    // Mode decode: 3 is treated like 2 (both streams)
    assign use_alu = (use_r != 2'd0);
    assign use_mul = (use_r != 2'd1);
    assign run     = (state == RUN);

    // FIFO status: extra pointer MSB distinguishes full from empty
    assign alu_empty = (alu_wp == alu_rp);
    assign mul_empty = (mul_wp == mul_rp);
    assign alu_full  = (alu_wp[AW] != alu_rp[AW]) && (alu_wp[AW-1:0] == alu_rp[AW-1:0]);
    assign mul_full  = (mul_wp[AW] != mul_rp[AW]) && (mul_wp[AW-1:0] == mul_rp[AW-1:0]);
    assign alu_head  = alu_mem[alu_rp[AW-1:0]];
    assign mul_head  = mul_mem[mul_rp[AW-1:0]];

    // Upstream handshake: only used streams accept, only while running
    assign io.brdma_alu_ready = run && use_alu && !alu_full;
    assign io.brdma_mul_ready = run && use_mul && !mul_full;
    assign alu_push = io.brdma_alu_valid && io.brdma_alu_ready;
    assign mul_push = io.brdma_mul_valid && io.brdma_mul_ready;

    // Downstream beat: every used head present; unused operands forced to zero
    assign io.bs_op_valid    = run && (!use_alu || !alu_empty) && (!use_mul || !mul_empty);
    assign fire              = io.bs_op_valid && io.bs_op_ready;
    assign last_c            = (use_alu && alu_head[DW]) || (use_mul && mul_head[DW]);
    assign mismatch          = use_alu && use_mul && (alu_head[DW] != mul_head[DW]);
    assign io.bs_op_last     = io.bs_op_valid && last_c;
    assign io.bs_op_alu_data = (io.bs_op_valid && use_alu) ? alu_head[DW-1:0] : '0;
    assign io.bs_op_mul_data = (io.bs_op_valid && use_mul) ? mul_head[DW-1:0] : '0;
    assign alu_pop           = fire && use_alu;
    assign mul_pop           = fire && use_mul;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (reg2dp_op_en) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (fire && last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, mode latch and status flags
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state   <= IDLE;
            use_r   <= 2'd2;
            op_done <= 1'b0;
            op_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_done <= (state_nxt == DONE);
            if (start) begin
                use_r  <= reg2dp_brdma_data_use;
                op_err <= 1'b0;
            end else if (fire && mismatch) begin
                op_err <= 1'b1;
            end
        end
    end

    // FIFO pointers; reset discards any buffered beats
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            alu_wp <= '0;
            alu_rp <= '0;
            mul_wp <= '0;
            mul_rp <= '0;
        end else begin
            if (alu_push) alu_wp <= alu_wp + PW'(1);
            if (alu_pop)  alu_rp <= alu_rp + PW'(1);
            if (mul_push) mul_wp <= mul_wp + PW'(1);
            if (mul_pop)  mul_rp <= mul_rp + PW'(1);
        end
    end

    // FIFO storage; contents are don't-care until pointers mark them valid
    always_ff @(posedge nvdla_core_clk) begin
        if (alu_push) alu_mem[alu_wp[AW-1:0]] <= io.brdma_alu_pd;
        if (mul_push) mul_mem[mul_wp[AW-1:0]] <= io.brdma_mul_pd;
    end

`ifdef SDP_BS_OPJOIN_PERF_EN
    // Saturating count of cycles where a beat is offered but not taken
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            dp2reg_bs_opjoin_stall <= 32'd0;
        end else if (start) begin
            dp2reg_bs_opjoin_stall <= 32'd0;
        end else if (io.bs_op_valid && !io.bs_op_ready && (dp2reg_bs_opjoin_stall != 32'hFFFF_FFFF)) begin
            dp2reg_bs_opjoin_stall <= dp2reg_bs_opjoin_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sdp_bs_operand_join.sv
// Testbench for sdp_bs_operand_join: table of layer scenarios plus random
// layers, each checked cycle by cycle against an occupancy/queue model.
module tb_sdp_bs_operand_join;
    localparam int unsigned DW    = 512;
    localparam int unsigned DEPTH = 4;

    typedef logic [DW:0] pd_t;

    typedef struct {
        int use_m;
        int n_alu;
        int n_mul;
        int alu_last;
        int mul_last;
        int rdy_mode;   // 0: always ready, 1: random, 2: stalled for 11 cycles
        bit keep_en;
        int exp_beats;
        bit exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_en = 1'b0;
    logic [1:0] data_use = 2'd0;
    logic       op_done;
    logic       op_err;
`ifdef SDP_BS_OPJOIN_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    sdp_bs_operand_join_if #(.DW(DW)) bus ();

    sdp_bs_operand_join #(.DW(DW), .DEPTH(DEPTH)) dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rst        (rst),
        .reg2dp_op_en          (op_en),
        .reg2dp_brdma_data_use (data_use),
        .io                    (bus),
        .op_done               (op_done),
        .op_err                (op_err)
`ifdef SDP_BS_OPJOIN_PERF_EN
        ,
        .dp2reg_bs_opjoin_stall(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic pd_t rand_pd(input bit last);
        pd_t r;
        for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
        r[DW] = last;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.brdma_alu_valid = 1'b0;
        bus.brdma_mul_valid = 1'b0;
        bus.brdma_alu_pd    = '0;
        bus.brdma_mul_pd    = '0;
        bus.bs_op_ready     = 1'b0;
    endtask

    // Assert reset, confirm every output is zero, release on a falling edge
    task automatic do_reset();
        idle_inputs();
        op_en = 1'b0;
        rst   = 1'b1;
        #1;
        chk1("rst_done", op_done, 1'b0);
        chk1("rst_err", op_err, 1'b0);
        chk1("rst_valid", bus.bs_op_valid, 1'b0);
        chk1("rst_alu_ready", bus.brdma_alu_ready, 1'b0);
        chk1("rst_mul_ready", bus.brdma_mul_ready, 1'b0);
        chk1("rst_last", bus.bs_op_last, 1'b0);
        chkw("rst_alu_data", bus.bs_op_alu_data, '0);
        chkw("rst_mul_data", bus.bs_op_mul_data, '0);
`ifdef SDP_BS_OPJOIN_PERF_EN
        chki("rst_stall", int'(stall_cnt), 0);
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one layer; expected beats come from the per-stream beat lists
    task automatic run_layer(input vec_t v);
        pd_t           aq[$];
        pd_t           mq[$];
        logic [DW-1:0] ea[$];
        logic [DW-1:0] em[$];
        bit            el[$];
        bit            emis[$];
        bit            ua, um, al, ml, exp_v, a_hs, m_hs, fire, err_now, done_seen;
        int            ai, mi, acnt, mcnt, stalls, beats;

        ua = (v.use_m != 0);
        um = (v.use_m != 1);
        for (int k = 0; k < v.n_alu; k++) aq.push_back(rand_pd(k == v.alu_last));
        for (int k = 0; k < v.n_mul; k++) mq.push_back(rand_pd(k == v.mul_last));
        for (int k = 0; k < 64; k++) begin
            al = ua ? aq[k][DW] : 1'b0;
            ml = um ? mq[k][DW] : 1'b0;
            ea.push_back(ua ? aq[k][DW-1:0] : '0);
            em.push_back(um ? mq[k][DW-1:0] : '0);
            el.push_back(al | ml);
            emis.push_back(ua && um && (al != ml));
            if (al | ml) break;
        end

        idle_inputs();
        op_en    = 1'b1;
        data_use = 2'(v.use_m);
        @(posedge clk);
        #1;
        op_en = v.keep_en;

        ai = 0; mi = 0; acnt = 0; mcnt = 0; stalls = 0; beats = 0;
        err_now = 1'b0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            bus.brdma_alu_valid = (ai < aq.size()) && (v.rdy_mode != 1 || $urandom_range(0, 3) != 0);
            bus.brdma_alu_pd    = (ai < aq.size()) ? aq[ai] : '0;
            bus.brdma_mul_valid = (mi < mq.size()) && (v.rdy_mode != 1 || $urandom_range(0, 3) != 0);
            bus.brdma_mul_pd    = (mi < mq.size()) ? mq[mi] : '0;
            case (v.rdy_mode)
                0:       bus.bs_op_ready = 1'b1;
                1:       bus.bs_op_ready = ($urandom_range(0, 2) != 0);
                default: bus.bs_op_ready = (cyc >= 11);
            endcase
            @(negedge clk);
            exp_v = (!ua || acnt > 0) && (!um || mcnt > 0);
            chk1("alu_ready", bus.brdma_alu_ready, ua && (acnt < int'(DEPTH)));
            chk1("mul_ready", bus.brdma_mul_ready, um && (mcnt < int'(DEPTH)));
            chk1("op_valid", bus.bs_op_valid, exp_v);
            if (exp_v && ea.size() > 0) begin
                chkw("alu_data", bus.bs_op_alu_data, ea[0]);
                chkw("mul_data", bus.bs_op_mul_data, em[0]);
                chk1("op_last", bus.bs_op_last, el[0]);
            end
            chk1("done_in_run", op_done, 1'b0);
            chk1("err_in_run", op_err, err_now);
            a_hs = bus.brdma_alu_valid && bus.brdma_alu_ready;
            m_hs = bus.brdma_mul_valid && bus.brdma_mul_ready;
            fire = bus.bs_op_valid && bus.bs_op_ready;
            if (exp_v && !bus.bs_op_ready) stalls++;
            @(posedge clk);
            #1;
            if (a_hs) begin ai++; acnt++; end
            if (m_hs) begin mi++; mcnt++; end
            if (fire) begin
                if (ua) acnt--;
                if (um) mcnt--;
                beats++;
                if (ea.size() > 0) begin
                    if (emis[0]) err_now = 1'b1;
                    done_seen = el[0];
                    void'(ea.pop_front());
                    void'(em.pop_front());
                    void'(el.pop_front());
                    void'(emis.pop_front());
                end
            end
        end
        if (!done_seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL layer_timeout: got %0d beats want last beat accepted", beats);
        end
        chki("beat_count", beats, v.exp_beats);
        idle_inputs();

        @(negedge clk);
        chk1("op_done", op_done, 1'b1);
        chk1("op_err", op_err, v.exp_err);
        chk1("done_valid", bus.bs_op_valid, 1'b0);
        chk1("done_alu_ready", bus.brdma_alu_ready, 1'b0);
        chk1("done_mul_ready", bus.brdma_mul_ready, 1'b0);
`ifdef SDP_BS_OPJOIN_PERF_EN
        chki("stall_count", int'(stall_cnt), stalls);
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("done_pulse_end", op_done, 1'b0);
        chk1("idle_valid", bus.bs_op_valid, 1'b0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        //          use alu mul alst mlst rdy keep beats err
        vecs[0] = '{2, 8, 8, 7, 7, 0, 1'b0, 8, 1'b0};   // both, 8 beats
        vecs[1] = '{1, 5, 5, 4, 4, 0, 1'b0, 5, 1'b0};   // ALU only, MUL valid held
        vecs[2] = '{2, 6, 6, 5, 5, 2, 1'b0, 6, 1'b0};   // downstream stall, FIFOs fill
        vecs[3] = '{2, 3, 4, 2, 3, 1, 1'b0, 3, 1'b1};   // last-flag mismatch
        vecs[4] = '{2, 3, 3, 2, 2, 1, 1'b1, 3, 1'b0};   // back-to-back, op_en held
        vecs[5] = '{0, 0, 4, 0, 3, 0, 1'b0, 4, 1'b0};   // MUL only, mode switched 2->0
        vecs[6] = '{3, 4, 4, 3, 3, 1, 1'b0, 4, 1'b0};   // reserved mode acts as both
        vecs[7] = '{1, 2, 0, 1, 0, 1, 1'b0, 2, 1'b0};   // ALU only, random handshakes

        idle_inputs();
        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_layer(vecs[i]);
            if (vecs[i].exp_err) do_reset();
        end

        // Reset in the middle of a layer after two beats are buffered
        op_en    = 1'b1;
        data_use = 2'd2;
        @(posedge clk);
        #1;
        op_en = 1'b0;
        bus.brdma_alu_valid = 1'b1;
        bus.brdma_mul_valid = 1'b1;
        bus.bs_op_ready     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.brdma_alu_pd = rand_pd(1'b0);
            bus.brdma_mul_pd = rand_pd(1'b0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        chk1("pre_rst_valid", bus.bs_op_valid, 1'b1);
        do_reset();
        rv = '{2, 4, 4, 3, 3, 0, 1'b0, 4, 1'b0};
        run_layer(rv);

        // Random layers
        for (int i = 0; i < 6; i++) begin
            rv.use_m     = int'($urandom_range(0, 3));
            rv.n_alu     = int'($urandom_range(1, 7));
            rv.n_mul     = rv.n_alu;
            rv.alu_last  = rv.n_alu - 1;
            rv.mul_last  = rv.n_mul - 1;
            rv.rdy_mode  = 1;
            rv.keep_en   = 1'b0;
            rv.exp_beats = rv.n_alu;
            rv.exp_err   = 1'b0;
            run_layer(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
